minterm_pattern_driver: RTL and testbench

//  Sequential driver for the 3-input minterm logic circuit (inputs A/B/C, output F).

---
 rtl/minterm_pattern_driver.sv | 145 ++++++++++++++
 tb/tb_minterm_pattern_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_pattern_driver.sv
`default_nettype none
// ============================================================================
//  Module   : minterm_pattern_driver
//  Brief    : Drives one of four decoded minterm patterns (H/I/J/K) onto A/B/C
//             for a programmable number of cycles, then an idle gap (100).
//             Optional F-level checker enabled by MINTERM_DRV_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module minterm_pattern_driver #(
    parameter int HOLD_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_sel,
    input  logic [HOLD_W-1:0]   req_hold,
    output logic                A,
    output logic                B,
    output logic                C,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] c_GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       c_IDLE_PAT = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         abc_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic [HOLD_W-1:0]  w_hold_load;
    logic [2:0]         w_sel_pat;

    // A hold of 0 is treated as a single drive cycle
    assign w_hold_load = (req_hold == '0) ? '0 : req_hold - 1'b1;
    assign w_sel_pat   = {1'b0, req_sel[0], req_sel[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            abc_q      <= c_IDLE_PAT;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && ready_q) begin
                        state_q    <= S_DRIVE;
                        abc_q      <= w_sel_pat;
                        hold_cnt_q <= w_hold_load;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (hold_cnt_q == '0) begin
                        state_q   <= S_GAP;
                        abc_q     <= c_IDLE_PAT;
                        gap_cnt_q <= c_GAP_LOAD;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    abc_q   <= c_IDLE_PAT;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is held low for as long as reset is asserted
    assign req_ready = ready_q & ~rst;
    assign {A, B, C} = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef MINTERM_DRV_CHECK_EN
    logic                err_q;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic                w_drive_last;
    logic                w_gap_last;
    logic                w_mismatch;

    assign w_drive_last = (state_q == S_DRIVE) && (hold_cnt_q == '0);
    assign w_gap_last   = (state_q == S_GAP) && (gap_cnt_q == '0);
    // F must be high on the driven minterm and low once A=1 clears the flags
    assign w_mismatch   = (w_drive_last && !f_in) || (w_gap_last && f_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (w_mismatch) begin
            err_q <= 1'b1;
            if (err_cnt_q != {ERRCNT_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic w_unused_f;
    assign w_unused_f = f_in;
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_minterm_pattern_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minterm_pattern_driver
//  Brief    : Randomised self-checking bench with a per-request timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_minterm_pattern_driver;

    localparam int HOLD_W = 8;
    localparam int GAP    = 1;
    localparam int EW     = 8;
    localparam int MAXC   = (1 << EW) - 1;
`ifdef MINTERM_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [1:0]        req_sel = '0;
    logic [HOLD_W-1:0] req_hold = '0;
    logic              f_in = 1'b0;
    wire               req_ready, A, B, C, busy, done, err;
    wire  [EW-1:0]     err_cnt;

    minterm_pattern_driver #(.HOLD_W(HOLD_W), .GAP_CYCLES(GAP), .ERRCNT_W(EW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_hold(req_hold), .A(A), .B(B), .C(C), .f_in(f_in),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    // Status vector: {A,B,C,busy,req_ready,done,err,err_cnt}
    wire [EW+7:0] obs = {A, B, C, busy, req_ready, done, err, err_cnt};

    function automatic logic [2:0] pat(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b000;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [EW+7:0] status(input logic [2:0] abc, input bit bsy,
                                              input bit rdy, input bit dn);
        return {abc, bsy, rdy, dn, exp_err, EW'(exp_cnt)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_sample(input bit mismatch);
        if (mismatch && CHK) begin
            exp_err = 1'b1;
            if (exp_cnt < MAXC) exp_cnt++;
        end
    endtask

    // Issue one request in the current (ready) cycle and follow it to its done cycle.
    task automatic run_req(input logic [1:0] sel, input logic [HOLD_W-1:0] hold,
                           input bit fd, input bit fg, input bit keep_valid,
                           input string tag);
        int n;
        logic [EW+7:0] e;
        n = (hold == 0) ? 1 : int'(hold);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL %s accept_ready got %b want 1", tag, req_ready);
        else n_pass++;
        req_valid = 1'b1;
        req_sel   = sel;
        req_hold  = hold;
        step();
        for (int i = 0; i < n; i++) begin
            if (!keep_valid) req_valid = 1'b0;
            req_sel  = 2'($urandom);
            req_hold = HOLD_W'($urandom);
            e = status(pat(sel), 1'b1, 1'b0, 1'b0);
            n_total++;
            if (obs !== e) $display("FAIL %s drive%0d got %b want %b", tag, i, obs, e);
            else n_pass++;
            f_in = fd;
            if (i == n - 1) model_sample(fd != 1'b1);
            step();
        end
        for (int g = 0; g < GAP; g++) begin
            e = status(3'b100, 1'b1, 1'b0, 1'b0);
            n_total++;
            if (obs !== e) $display("FAIL %s gap%0d got %b want %b", tag, g, obs, e);
            else n_pass++;
            f_in = fg;
            if (g == GAP - 1) model_sample(fg != 1'b0);
            step();
        end
        e = status(3'b100, 1'b0, 1'b1, 1'b1);
        n_total++;
        if (obs !== e) $display("FAIL %s done got %b want %b", tag, obs, e);
        else n_pass++;
    endtask

    task automatic idle_step(input string tag);
        logic [EW+7:0] e;
        req_valid = 1'b0;
        step();
        e = status(3'b100, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (obs !== e) $display("FAIL %s idle got %b want %b", tag, obs, e);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [EW+7:0] e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (req_ready !== 1'b0) $display("FAIL rst_ready cyc%0d got %b want 0", i, req_ready);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        exp_err = 1'b0;
        exp_cnt = 0;
        e = status(3'b100, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (obs !== e) $display("FAIL reset_state got %b want %b", obs, e);
        else n_pass++;
    endtask

    task automatic test_single();
        run_req(2'd1, 8'd3, 1'b1, 1'b0, 1'b0, "sel1_hold3");
        idle_step("after_sel1");
        run_req(2'd3, 8'd0, 1'b1, 1'b0, 1'b0, "sel3_hold0");
        idle_step("after_sel3");
    endtask

    task automatic test_back_to_back();
        run_req(2'd0, 8'd2, 1'b1, 1'b0, 1'b1, "b2b_first");
        run_req(2'd2, 8'd2, 1'b1, 1'b0, 1'b1, "b2b_second");
        idle_step("after_b2b");
    endtask

    task automatic test_long_hold();
        run_req(2'd2, 8'hFF, 1'b1, 1'b0, 1'b0, "hold_max");
        idle_step("after_hold_max");
    endtask

    task automatic test_checker();
        logic [EW-1:0] want;
        run_req(2'd0, 8'd1, 1'b0, 1'b0, 1'b0, "f_low");
        idle_step("after_f_low");
        for (int r = 0; r < 300; r++) begin
            run_req(2'($urandom), HOLD_W'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0, "f_inv");
            idle_step("after_f_inv");
        end
        want = CHK ? EW'(MAXC) : '0;
        n_total++;
        if (err_cnt !== want) $display("FAIL err_cnt_sat got %0d want %0d", err_cnt, want);
        else n_pass++;
    endtask

    task automatic test_random();
        bit b2b = 1'b0;
        for (int r = 0; r < 40; r++) begin
            b2b = 1'($urandom);
            run_req(2'($urandom), HOLD_W'($urandom_range(0, 12)), 1'($urandom),
                    1'($urandom), b2b, "rand");
            if (!b2b || r == 39) begin
                for (int k = 0; k <= int'($urandom_range(0, 2)); k++) idle_step("rand_idle");
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [EW+7:0] e;
        req_valid = 1'b1;
        req_sel   = 2'd1;
        req_hold  = 8'd10;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        e = {3'b100, 1'b0, 1'b0, 1'b0, 1'b0, {EW{1'b0}}};
        n_total++;
        if (obs !== e) $display("FAIL mid_rst got %b want %b", obs, e);
        else n_pass++;
        rst = 1'b0;
        #1;
        exp_err = 1'b0;
        exp_cnt = 0;
        idle_step("mid_rst_no_done");
        run_req(2'd2, 8'd2, 1'b1, 1'b0, 1'b0, "post_rst");
        idle_step("after_post_rst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_long_hold();
        test_random();
        test_checker();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
